// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian words from a byte stream and writes them while holding the CPU in reset.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] words_loaded
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]         FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CW-1:0]         WL_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE    = ADDR_WIDTH'(1);
    localparam logic [8:0]            DEPTH9     = 9'(2 ** ADDR_WIDTH);
    localparam logic [TW-1:0]         TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]         TO_ONE     = TW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        WRITE = 3'd3,
        CHECK = 3'd4
`else
        WRITE = 3'd3
`endif
    } state_t;

    state_t                state, next_state;
    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [CW-1:0]         word_count;
    logic [23:0]           word_buf;
    logic [TW-1:0]         idle_cnt;
    logic                  counting, timeout_hit, last_word;
    logic                  start, accept_count, capture, fail, finish;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign mem_we   = (state == WRITE);
    assign busy     = (state != IDLE);
    assign cpu_hold = busy;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign counting = (state == COUNT) || (state == DATA) || (state == CHECK);
`else
    assign counting = (state == COUNT) || (state == DATA);
`endif
    assign timeout_hit = counting && !rx_valid && (idle_cnt == TO_LAST);
    assign last_word   = ((words_loaded + WL_ONE) == word_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        start        = 1'b0;
        accept_count = 1'b0;
        capture      = 1'b0;
        fail         = 1'b0;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    start      = 1'b1;
                    next_state = COUNT;
                end
            end
            COUNT: begin
                if (rx_valid) begin
                    if ({1'b0, rx_data} > DEPTH9) begin
                        fail       = 1'b1;
                        next_state = IDLE;
                    end else begin
                        accept_count = 1'b1;
                        next_state   = DATA;
                    end
                end else if (timeout_hit) begin
                    fail       = 1'b1;
                    next_state = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    capture = 1'b1;
                    if (byte_idx == 2'd3) next_state = WRITE;
                end else if (timeout_hit) begin
                    fail       = 1'b1;
                    next_state = IDLE;
                end
            end
            WRITE: begin
                // A byte arriving here belongs to the next word (or is the checksum after the last word).
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = CHECK;
                    if (rx_valid) begin
                        next_state = IDLE;
                        if (rx_data == csum) finish = 1'b1;
                        else                 fail   = 1'b1;
                    end
`else
                    next_state = IDLE;
                    finish     = 1'b1;
`endif
                end else begin
                    next_state = DATA;
                    capture    = rx_valid;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    next_state = IDLE;
                    if (rx_data == csum) finish = 1'b1;
                    else                 fail   = 1'b1;
                end else if (timeout_hit) begin
                    fail       = 1'b1;
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx     <= 2'd0;
            word_idx     <= '0;
            word_count   <= '0;
            word_buf     <= '0;
            idle_cnt     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            done <= finish;
            if (start) begin
                error        <= 1'b0;
                words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum         <= '0;
`endif
            end
            if (fail) error <= 1'b1;
            if (accept_count) begin
                word_count <= (rx_data == 8'd0) ? FULL_COUNT : CW'(rx_data);
                byte_idx   <= 2'd0;
                word_idx   <= '0;
            end
            if (capture) begin
                byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= csum + rx_data;
`endif
                // The fourth byte goes straight into the write register, so WRITE sees the full word.
                case (byte_idx)
                    2'd0: word_buf[7:0]   <= rx_data;
                    2'd1: word_buf[15:8]  <= rx_data;
                    2'd2: word_buf[23:16] <= rx_data;
                    default: begin
                        mem_wdata <= {rx_data, word_buf};
                        mem_addr  <= {{(30 - ADDR_WIDTH){1'b0}}, word_idx, 2'b00};
                    end
                endcase
            end
            if (state == WRITE) begin
                word_idx     <= word_idx + IDX_ONE;
                words_loaded <= words_loaded + WL_ONE;
            end
            if (rx_valid || !counting) idle_cnt <= '0;
            else                       idle_cnt <= idle_cnt + TO_ONE;
        end
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. The CPU fetch path reads the instruction ROM with a byte address and uses addr[31:2] as the word index; this block fills that memory from a byte stream (e.g. UART RX).
- Assembles little-endian 32-bit words from the stream.
- Issues word-aligned write strobes into the instruction memory.
- Holds the CPU in reset for the whole load.

Parameters:
- ADDR_WIDTH, 4: word-index width; memory depth DEPTH = 2**ADDR_WIDTH words (16).
- TIMEOUT_CYCLES, 100000: maximum idle clocks between bytes during a load before it aborts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse.
- mem_addr  out  32  byte address, always word-aligned (bits [1:0] = 0).
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  high for the whole load; drives CPU reset.
- busy  out  1  high when the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a load completes successfully.
- error  out  1  sticky failure flag; cleared only by the next accepted load_start or by reset.
- words_loaded  out  ADDR_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0: mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, words_loaded. The byte-index, word-index and timeout counters are also cleared. A reset during a load abandons it; no further mem_we is issued.
- States: IDLE, COUNT, DATA, WRITE, CHECK (CHECK exists only with the optional feature).
- IDLE
  - rx_valid is ignored.
  - On load_start: go to COUNT. Clear error and words_loaded. Assert cpu_hold and busy from the next cycle.
- COUNT
  - The first rx_valid byte is the word count N. N = 0 means DEPTH.
  - If N > DEPTH: set error and go to IDLE, with no writes.
  - Otherwise go to DATA with byte_idx = 0 and word_idx = 0.
- DATA
  - Each rx_valid byte is placed at bits [8*byte_idx+7 : 8*byte_idx], so the first byte lands in [7:0].
  - byte_idx wraps 3 -> 0.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle)
  - mem_we = 1, mem_addr = {word_idx, 2'b00} zero-extended to 32 bits, mem_wdata = the assembled word.
  - Latency: mem_we is high in the cycle after the clock edge that captured the 4th byte.
  - Then increment word_idx and words_loaded.
  - If words_loaded now equals N: go to CHECK if the feature is enabled, otherwise go to IDLE and pulse done.
  - Otherwise return to DATA.
  - An rx_valid arriving during WRITE is captured as byte 0 of the next word (no byte loss).
- Exit from a load
  - done pulses in the first IDLE cycle.
  - cpu_hold and busy fall in that same cycle.
  - mem_we is 0 everywhere outside WRITE.
  - mem_addr and mem_wdata hold their last values.
- Timeout
  - The counter clears on every rx_valid and counts while in COUNT, DATA or CHECK.
  - When it reaches TIMEOUT_CYCLES: set error and go to IDLE. cpu_hold drops and done is not pulsed.
  - Words already written remain in memory.
- load_start while busy: ignored.
- Address wrap: impossible, because N <= DEPTH is enforced.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the FSM enters CHECK.
  - The next rx_valid byte is compared with the 8-bit modulo-256 sum of all data bytes (the count byte is excluded).
  - Match: go to IDLE and pulse done.
  - Mismatch: set error and go to IDLE with no done pulse. The memory writes are not undone.
  - The timeout also applies in CHECK.
- Not defined: the CHECK state, the sum register and the compare logic are absent; done follows the last WRITE directly.

Test Plan:
- Two-word load: load_start, then bytes 02, 33 02 11 00, B3 02 11 40.
  - Required: mem_we pulses at addr 0x0 with data 0x00110233 and at addr 0x4 with data 0x401102B3.
  - done pulses once; words_loaded = 2; cpu_hold high from the cycle after load_start until the done cycle.
- Checksum (IMEM_LOADER_CHECKSUM_EN): same stream plus byte 4C -> done, error = 0.
  - Same stream plus byte 4D -> error = 1, no done pulse, both writes still occurred.
- Count edge cases:
  - Count byte 00 followed by 64 bytes -> 16 writes at addresses 0x00..0x3C, then done.
  - Count byte 11 (17) -> error = 1 with no mem_we.
- Timeout: count 01, bytes AA BB, then silence for TIMEOUT_CYCLES clocks -> error = 1, busy = 0, cpu_hold = 0, no mem_we.
  - A following load_start clears error.
- Robustness:
  - rx_valid in IDLE is ignored.
  - A second load_start mid-load is ignored.
  - Back-to-back rx_valid on consecutive cycles across WRITE loses no byte.
  - Reset asserted asynchronously mid-DATA forces all outputs to 0 immediately, with no further writes.
